// File: rtl/axi_burst_mem_slave.sv
// axi_burst_mem_slave: AXI4 FIXED/INCR burst memory slave with read latency and SLVERR reporting.
// Defining AXI_SLV_WRAP_EN adds WRAP burst support; otherwise WRAP bursts answer SLVERR.
module axi_burst_mem_slave #(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 32,
   parameter int ID_W      = 4,
   parameter int MEM_DEPTH = 4096,
   parameter int READ_LAT  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ID_W-1:0]     i_aw_id,
   input  logic [ADDR_W-1:0]   i_aw_addr,
   input  logic [7:0]          i_aw_len,
   input  logic [2:0]          i_aw_size,
   input  logic [1:0]          i_aw_burst,
   input  logic                i_aw_valid,
   output logic                o_aw_ready,
   input  logic [DATA_W-1:0]   i_w_data,
   input  logic [DATA_W/8-1:0] i_w_strb,
   input  logic                i_w_last,
   input  logic                i_w_valid,
   output logic                o_w_ready,
   output logic [ID_W-1:0]     o_b_id,
   output logic [1:0]          o_b_resp,
   output logic                o_b_valid,
   input  logic                i_b_ready,
   input  logic [ID_W-1:0]     i_ar_id,
   input  logic [ADDR_W-1:0]   i_ar_addr,
   input  logic [7:0]          i_ar_len,
   input  logic [2:0]          i_ar_size,
   input  logic [1:0]          i_ar_burst,
   input  logic                i_ar_valid,
   output logic                o_ar_ready,
   output logic [ID_W-1:0]     o_r_id,
   output logic [DATA_W-1:0]   o_r_data,
   output logic [1:0]          o_r_resp,
   output logic                o_r_last,
   output logic                o_r_valid,
   input  logic                i_r_ready
);
   localparam int BPW = DATA_W / 8;
   localparam int OFF = $clog2(BPW);
   localparam int IW  = $clog2(MEM_DEPTH);
   localparam int XW  = ADDR_W - OFF;
   localparam logic [XW-1:0] DEPTH = XW'(MEM_DEPTH);
   localparam bit WRAP_EN =
`ifdef AXI_SLV_WRAP_EN
      1'b1;
`else
      1'b0;
`endif

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

   logic [DATA_W-1:0] r_mem [MEM_DEPTH];

   function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                input logic [2:0] size, input logic [1:0] burst);
      logic [ADDR_W-1:0] inc, wm;
      inc = a + (ADDR_W'(1) << size);
      wm  = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
      return burst == 2'b01 ? inc : burst == 2'b10 ? ((a & ~wm) | (inc & wm)) : a;
   endfunction

   // Whole-transaction errors; WRAP start must be aligned to the beat size
   function automatic logic f_bad(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
      return size > 3'(OFF) || burst == 2'b11 || (burst == 2'b10 && !(WRAP_EN &&
             (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) &&
             (a & ((ADDR_W'(1) << size) - ADDR_W'(1))) == '0));
   endfunction

   function automatic logic f_ibad(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:OFF] >= DEPTH;
   endfunction

   function automatic logic [IW-1:0] f_idx(input logic [ADDR_W-1:0] a);
      return a[OFF +: IW];
   endfunction

   w_state_t          r_wstate, w_wnext;
   logic [ID_W-1:0]   r_aw_id;
   logic [ADDR_W-1:0] r_aw_addr;
   logic [7:0]        r_aw_len, r_wcnt;
   logic [2:0]        r_aw_size;
   logic [1:0]        r_aw_burst;
   logic              r_werr, r_wbad, w_aw_hs, w_wbeat, w_wend;

   assign w_aw_hs = i_aw_valid && o_aw_ready;
   assign w_wbeat = o_w_ready && i_w_valid;
   assign w_wend  = r_wcnt == r_aw_len;

   always_ff @(posedge clk)
      r_wstate <= rst ? W_IDLE : w_wnext;

   always_comb
      w_wnext = r_wstate == W_IDLE ? (w_aw_hs ? W_DATA : W_IDLE) :
                r_wstate == W_DATA ? (w_wbeat && w_wend ? W_RESP : W_DATA) :
                (i_b_ready ? W_IDLE : W_RESP);

   always_comb begin
      o_aw_ready = !rst && r_wstate == W_IDLE;
      o_w_ready  = r_wstate == W_DATA;
      o_b_valid  = r_wstate == W_RESP;
      o_b_resp   = r_wstate == W_RESP && (r_werr || r_wbad) ? 2'b10 : 2'b00;
      o_b_id     = r_aw_id;
   end

   always_ff @(posedge clk)
      if (rst) begin
         r_aw_id    <= '0;
         r_aw_addr  <= '0;
         r_aw_len   <= '0;
         r_aw_size  <= '0;
         r_aw_burst <= '0;
         r_wcnt     <= '0;
         r_werr     <= 1'b0;
         r_wbad     <= 1'b0;
      end else if (w_aw_hs) begin
         r_aw_id    <= i_aw_id;
         r_aw_addr  <= i_aw_addr;
         r_aw_len   <= i_aw_len;
         r_aw_size  <= i_aw_size;
         r_aw_burst <= i_aw_burst;
         r_wcnt     <= '0;
         r_werr     <= 1'b0;
         r_wbad     <= f_bad(i_aw_addr, i_aw_len, i_aw_size, i_aw_burst);
      end else if (w_wbeat) begin
         r_wcnt     <= r_wcnt + 8'd1;
         r_aw_addr  <= f_next(r_aw_addr, r_aw_len, r_aw_size, r_aw_burst);
         r_werr     <= r_werr || (i_w_last != w_wend) || f_ibad(r_aw_addr);
      end

   always_ff @(posedge clk)
      if (w_wbeat && !r_wbad && !f_ibad(r_aw_addr))
         for (int i = 0; i < BPW; i++)
            if (i_w_strb[i]) r_mem[f_idx(r_aw_addr)][8*i +: 8] <= i_w_data[8*i +: 8];

   r_state_t          r_rstate, w_rnext;
   logic [ID_W-1:0]   r_ar_id;
   logic [ADDR_W-1:0] r_ar_addr, w_raddr, w_rnext_addr;
   logic [7:0]        r_ar_len, r_rcnt;
   logic [2:0]        r_ar_size;
   logic [1:0]        r_ar_burst, r_rresp;
   logic [3:0]        r_lat;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rbad, w_ar_hs, w_r_hs, w_rend, w_rload, w_rbad;

   assign w_ar_hs      = i_ar_valid && o_ar_ready;
   assign w_r_hs       = r_rstate == R_DATA && i_r_ready;
   assign w_rend       = r_rcnt == r_ar_len;
   assign w_rnext_addr = f_next(r_ar_addr, r_ar_len, r_ar_size, r_ar_burst);
   assign w_rload      = (w_ar_hs && READ_LAT == 0) || (r_rstate == R_WAIT && r_lat <= 4'd1) || (w_r_hs && !w_rend);
   assign w_raddr      = r_rstate == R_IDLE ? i_ar_addr : r_rstate == R_WAIT ? r_ar_addr : w_rnext_addr;
   assign w_rbad       = (r_rstate == R_IDLE ? f_bad(i_ar_addr, i_ar_len, i_ar_size, i_ar_burst) : r_rbad) || f_ibad(w_raddr);

   always_ff @(posedge clk)
      r_rstate <= rst ? R_IDLE : w_rnext;

   always_comb
      w_rnext = r_rstate == R_IDLE ? (w_ar_hs ? (READ_LAT == 0 ? R_DATA : R_WAIT) : R_IDLE) :
                r_rstate == R_WAIT ? (r_lat <= 4'd1 ? R_DATA : R_WAIT) :
                (w_r_hs && w_rend ? R_IDLE : R_DATA);

   always_comb begin
      o_ar_ready = !rst && r_rstate == R_IDLE;
      o_r_valid  = r_rstate == R_DATA;
      o_r_last   = r_rstate == R_DATA && w_rend;
      o_r_id     = r_ar_id;
      o_r_data   = r_rdata;
      o_r_resp   = r_rresp;
   end

   always_ff @(posedge clk)
      if (rst) begin
         r_ar_id    <= '0;
         r_ar_addr  <= '0;
         r_ar_len   <= '0;
         r_ar_size  <= '0;
         r_ar_burst <= '0;
         r_rcnt     <= '0;
         r_lat      <= '0;
         r_rbad     <= 1'b0;
         r_rdata    <= '0;
         r_rresp    <= 2'b00;
      end else begin
         if (w_ar_hs) begin
            r_ar_id    <= i_ar_id;
            r_ar_addr  <= i_ar_addr;
            r_ar_len   <= i_ar_len;
            r_ar_size  <= i_ar_size;
            r_ar_burst <= i_ar_burst;
            r_rcnt     <= '0;
            r_lat      <= 4'(READ_LAT);
            r_rbad     <= f_bad(i_ar_addr, i_ar_len, i_ar_size, i_ar_burst);
         end else if (r_rstate == R_WAIT)
            r_lat <= r_lat - 4'd1;
         if (w_r_hs && !w_rend) begin
            r_rcnt    <= r_rcnt + 8'd1;
            r_ar_addr <= w_rnext_addr;
         end
         if (w_rload) begin
            r_rdata <= w_rbad ? '0 : r_mem[f_idx(w_raddr)];
            r_rresp <= w_rbad ? 2'b10 : 2'b00;
         end
      end
endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// tb_axi_burst_mem_slave: directed bench for axi_burst_mem_slave (READ_LAT 2 main instance, READ_LAT 0 side instance).
module tb_axi_burst_mem_slave;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;

   logic [3:0]  aw_id = 0, ar_id = 0, b_id, r_id, z_b_id, z_r_id;
   logic [31:0] aw_addr = 0, ar_addr = 0;
   logic [7:0]  aw_len = 0, ar_len = 0, w_strb = 0;
   logic [2:0]  aw_size = 3, ar_size = 3;
   logic [1:0]  aw_burst = 1, ar_burst = 1, b_resp, r_resp, z_b_resp, z_r_resp;
   logic [63:0] w_data = 0, r_data, z_r_data;
   logic aw_valid = 0, w_last = 0, w_valid = 0, b_ready = 0, ar_valid = 0, r_ready = 0;
   logic aw_ready, w_ready, b_valid, ar_ready, r_last, r_valid;
   logic z_ar_valid = 0, z_r_ready = 0;
   logic z_aw_ready, z_w_ready, z_b_valid, z_ar_ready, z_r_last, z_r_valid;

   axi_burst_mem_slave dut (
      .clk(clk), .rst(rst),
      .i_aw_id(aw_id), .i_aw_addr(aw_addr), .i_aw_len(aw_len), .i_aw_size(aw_size), .i_aw_burst(aw_burst),
      .i_aw_valid(aw_valid), .o_aw_ready(aw_ready),
      .i_w_data(w_data), .i_w_strb(w_strb), .i_w_last(w_last), .i_w_valid(w_valid), .o_w_ready(w_ready),
      .o_b_id(b_id), .o_b_resp(b_resp), .o_b_valid(b_valid), .i_b_ready(b_ready),
      .i_ar_id(ar_id), .i_ar_addr(ar_addr), .i_ar_len(ar_len), .i_ar_size(ar_size), .i_ar_burst(ar_burst),
      .i_ar_valid(ar_valid), .o_ar_ready(ar_ready),
      .o_r_id(r_id), .o_r_data(r_data), .o_r_resp(r_resp), .o_r_last(r_last), .o_r_valid(r_valid), .i_r_ready(r_ready)
   );

   axi_burst_mem_slave #(.READ_LAT(0)) dut0 (
      .clk(clk), .rst(rst),
      .i_aw_id(aw_id), .i_aw_addr(aw_addr), .i_aw_len(aw_len), .i_aw_size(aw_size), .i_aw_burst(aw_burst),
      .i_aw_valid(1'b0), .o_aw_ready(z_aw_ready),
      .i_w_data(w_data), .i_w_strb(w_strb), .i_w_last(1'b0), .i_w_valid(1'b0), .o_w_ready(z_w_ready),
      .o_b_id(z_b_id), .o_b_resp(z_b_resp), .o_b_valid(z_b_valid), .i_b_ready(1'b1),
      .i_ar_id(ar_id), .i_ar_addr(ar_addr), .i_ar_len(ar_len), .i_ar_size(ar_size), .i_ar_burst(ar_burst),
      .i_ar_valid(z_ar_valid), .o_ar_ready(z_ar_ready),
      .o_r_id(z_r_id), .o_r_data(z_r_data), .o_r_resp(z_r_resp), .o_r_last(z_r_last), .o_r_valid(z_r_valid),
      .i_r_ready(z_r_ready)
   );

   int n_pass = 0, n_tot = 0;
   logic [63:0] rd_d [0:255];
   logic [1:0]  rd_r [0:255];
   logic        rd_l [0:255];
   logic [3:0]  rd_id;
   int rd_n, rd_lat;
   logic [1:0] wr_resp;
   logic [3:0] wr_id;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [63:0] d0, input logic [7:0] strb, input bit early);
      int g;
      @(negedge clk);
      aw_id = id; aw_addr = addr; aw_len = len; aw_size = 3; aw_burst = burst; aw_valid = 1;
      g = 0;
      while (!aw_ready && g < 50) begin @(negedge clk); g++; end
      chk("aw_handshake", aw_ready, 1);
      @(negedge clk);
      aw_valid = 0;
      for (int k = 0; k <= int'(len); k++) begin
         w_data = d0 + 64'(k); w_strb = strb; w_last = early ? (k == 0) : (k == int'(len)); w_valid = 1;
         g = 0;
         while (!w_ready && g < 50) begin @(negedge clk); g++; end
         if (!w_ready) chk("w_handshake", w_ready, 1);
         @(negedge clk);
      end
      w_valid = 0; w_last = 0; b_ready = 1;
      g = 0;
      while (!b_valid && g < 50) begin @(negedge clk); g++; end
      if (!b_valid) chk("b_valid_timeout", b_valid, 1);
      wr_resp = b_resp; wr_id = b_id;
      @(negedge clk);
      b_ready = 0;
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input bit toggle);
      int g;
      bit st;
      logic [63:0] sd;
      logic sl;
      @(negedge clk);
      ar_id = id; ar_addr = addr; ar_len = len; ar_size = 3; ar_burst = burst; ar_valid = 1; r_ready = 0;
      g = 0;
      while (!ar_ready && g < 50) begin @(negedge clk); g++; end
      chk("ar_handshake", ar_ready, 1);
      @(negedge clk);
      ar_valid = 0; rd_lat = 1;
      while (!r_valid && rd_lat < 50) begin @(negedge clk); rd_lat++; end
      rd_n = 0; st = 0; g = 0;
      while (rd_n <= int'(len) && g < 1000) begin
         r_ready = toggle ? !r_ready : 1'b1;
         if (r_valid) begin
            if (st) begin
               chk("r_stall_data", r_data, sd);
               chk("r_stall_last", r_last, sl);
               st = 0;
            end
            if (r_ready) begin
               rd_d[rd_n] = r_data; rd_r[rd_n] = r_resp; rd_l[rd_n] = r_last; rd_id = r_id; rd_n++;
            end else begin
               st = 1; sd = r_data; sl = r_last;
            end
         end
         @(negedge clk);
         g++;
      end
      r_ready = 0;
      if (rd_n <= int'(len)) chk("r_beat_count", rd_n, len + 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int g, cnt;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_aw_ready", aw_ready, 0);
      chk("rst_ar_ready", ar_ready, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_r_valid", r_valid, 0);
      chk("rst_r_last", r_last, 0);
      chk("rst_r_data", r_data, 0);
      chk("rst_b_resp", b_resp, 0);
      chk("rst_r_resp", r_resp, 0);
      chk("rst_b_id", b_id, 0);
      chk("rst_r_id", r_id, 0);
      rst = 0;
      @(negedge clk);
      chk("post_rst_aw_ready", aw_ready, 1);
      chk("post_rst_ar_ready", ar_ready, 1);

      // zero-latency instance: valid the cycle after the AR handshake
      ar_addr = 32'h0; ar_len = 0; ar_size = 3; ar_burst = 1; ar_id = 7; z_ar_valid = 1;
      g = 0;
      while (!z_ar_ready && g < 50) begin @(negedge clk); g++; end
      @(negedge clk);
      z_ar_valid = 0; rd_lat = 1;
      while (!z_r_valid && rd_lat < 50) begin @(negedge clk); rd_lat++; end
      chk("lat0_first_valid", rd_lat, 1);
      chk("lat0_r_last", z_r_last, 1);
      chk("lat0_r_id", z_r_id, 7);
      z_r_ready = 1;
      @(negedge clk);
      z_r_ready = 0;
      chk("lat0_done", z_r_valid, 0);

      do_write(3, 32'h100, 0, 2'b01, 64'hDEADBEEF_01234567, 8'hFF, 0);
      chk("single_b_resp", wr_resp, 2'b00);
      chk("single_b_id", wr_id, 3);
      do_read(5, 32'h100, 0, 2'b01, 0);
      chk("lat2_first_valid", rd_lat, 3);
      chk("single_r_data", rd_d[0], 64'hDEADBEEF_01234567);
      chk("single_r_last", rd_l[0], 1);
      chk("single_r_resp", rd_r[0], 2'b00);
      chk("single_r_id", rd_id, 5);

      do_write(1, 32'h200, 3, 2'b01, 64'd1, 8'hFF, 0);
      chk("incr_b_resp", wr_resp, 2'b00);
      do_read(2, 32'h200, 3, 2'b01, 1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("incr_r_data%0d", k), rd_d[k], 64'(k + 1));
         chk($sformatf("incr_r_last%0d", k), rd_l[k], k == 3);
      end

      do_write(1, 32'h100, 0, 2'b01, 64'h11111111_22222222, 8'h0F, 0);
      do_read(1, 32'h100, 0, 2'b01, 0);
      chk("strobe_merge", rd_d[0], 64'hDEADBEEF_22222222);

      do_write(2, 32'h0, 0, 2'b01, 64'hAAAA5555_AAAA5555, 8'hFF, 0);
      chk("word0_b_resp", wr_resp, 2'b00);
      do_write(2, 32'h8000, 0, 2'b01, 64'h0BAD, 8'hFF, 0);
      chk("oob_write_b_resp", wr_resp, 2'b10);
      do_write(4, 32'h400, 1, 2'b01, 64'h77, 8'hFF, 1);
      chk("early_last_b_resp", wr_resp, 2'b10);
      chk("early_last_b_id", wr_id, 4);
      do_read(0, 32'h0, 0, 2'b01, 0);
      chk("word0_unchanged", rd_d[0], 64'hAAAA5555_AAAA5555);
      do_read(0, 32'h8000, 0, 2'b01, 0);
      chk("oob_read_resp", rd_r[0], 2'b10);
      chk("oob_read_data", rd_d[0], 0);

      do_write(6, 32'h300, 3, 2'b01, 64'h10, 8'hFF, 0);
      do_read(6, 32'h308, 1, 2'b00, 0);
      chk("fixed_beat0", rd_d[0], 64'h11);
      chk("fixed_beat1", rd_d[1], 64'h11);
      chk("fixed_last1", rd_l[1], 1);
      do_read(6, 32'h318, 3, 2'b10, 0);
      for (int k = 0; k < 4; k++) begin
`ifdef AXI_SLV_WRAP_EN
         chk($sformatf("wrap_data%0d", k), rd_d[k], k == 0 ? 64'h13 : 64'(16 + k - 1));
         chk($sformatf("wrap_resp%0d", k), rd_r[k], 2'b00);
`else
         chk($sformatf("wrap_data%0d", k), rd_d[k], 64'h0);
         chk($sformatf("wrap_resp%0d", k), rd_r[k], 2'b10);
`endif
      end
      chk("wrap_last3", rd_l[3], 1);

      @(negedge clk);
      ar_id = 9; ar_addr = 32'h200; ar_len = 7; ar_size = 3; ar_burst = 1; ar_valid = 1;
      g = 0;
      while (!ar_ready && g < 50) begin @(negedge clk); g++; end
      @(negedge clk);
      ar_valid = 0; r_ready = 1; cnt = 0; g = 0;
      while (cnt < 2 && g < 50) begin
         if (r_valid) cnt++;
         @(negedge clk);
         g++;
      end
      chk("midburst_valid", r_valid, 1);
      chk("midburst_beat2", r_data, 64'd3);
      rst = 1; r_ready = 0;
      @(negedge clk);
      chk("midburst_rst_r_valid", r_valid, 0);
      chk("midburst_rst_r_data", r_data, 0);
      chk("midburst_rst_ar_ready", ar_ready, 0);
      rst = 0;
      @(negedge clk);
      chk("after_rst_ar_ready", ar_ready, 1);
      do_read(3, 32'h208, 0, 2'b01, 0);
      chk("after_rst_data", rd_d[0], 64'd2);
      chk("after_rst_last", rd_l[0], 1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
